// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state, slot type and sizing helper for the sdram arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    // Slot fields are sized for the largest legal configuration; the top slices what it uses.
    localparam int SLOT_ADDR_MAX  = 32;
    localparam int SLOT_DATA_MAX  = 32;
    localparam int SLOT_BE_MAX    = 4;
    localparam int SLOT_OWNER_MAX = 3;

    typedef struct packed {
        logic                      rd;
        logic [SLOT_BE_MAX-1:0]    wr;
        logic [SLOT_ADDR_MAX-1:0]  addr;
        logic [SLOT_DATA_MAX-1:0]  wdata;
        logic [SLOT_OWNER_MAX-1:0] owner;
    } slot_t;

    function automatic int owner_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after the pointer
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = owner_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_pending,
    input  logic [PTR_W-1:0]     i_pointer,
    output logic [PTR_W-1:0]     o_grant,
    output logic                 o_any_pending
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant       = '0;
        w_idx         = '0;
        o_any_pending = |i_pending;
        // Scan farthest offset first so the nearest pending port after the pointer wins.
        for (int off = NUM_PORTS; off >= 1; off--) begin
            w_idx = PTR_W'((int'(i_pointer) + off) % NUM_PORTS);
            if (i_pending[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one sdram_core control port
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int WORD_LEN       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_rd,
    input  logic [NUM_PORTS*WORD_LEN-1:0]   req_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_rdy,
    output logic [NUM_PORTS-1:0]            rsp_rvalid,
    output logic [NUM_PORTS-1:0]            rsp_wvalid,
    output logic [NUM_PORTS-1:0]            rsp_error,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            m_rd,
    output logic [WORD_LEN-1:0]             m_wr,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    input  logic                            m_rdy,
    input  logic                            m_rvalid,
    input  logic                            m_wvalid,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_error,
    output logic                            busy,
    output logic                            timeout_sticky
);

    localparam int PTR_W = owner_width(NUM_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    slot_t            r_slot;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_sticky;

    logic [NUM_PORTS-1:0] w_pending;
    logic [PTR_W-1:0]     w_grant;
    logic                 w_any_pending;
    logic                 w_grant_rd;
    logic [WORD_LEN-1:0]  w_grant_wr;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_done_ok;
    logic                 w_timeout;
    logic [PTR_W-1:0]     w_owner;
    logic [NUM_PORTS-1:0] w_owner_hot;
    logic                 w_unused;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_pending[i] = req_rd[i] | (|req_wr[i*WORD_LEN +: WORD_LEN]);
        end
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .i_pending     (w_pending),
        .i_pointer     (r_ptr),
        .o_grant       (w_grant),
        .o_any_pending (w_any_pending)
    );

    assign w_grant_rd  = req_rd[w_grant];
    assign w_grant_wr  = req_wr[w_grant*WORD_LEN +: WORD_LEN];
    assign w_illegal   = w_grant_rd && (w_grant_wr != '0);
    assign w_accept    = (r_state == ARB) && w_any_pending;
    assign w_done_ok   = (r_state == WAIT) && (m_rvalid || m_wvalid);
    // A completion arriving on the last counted cycle still beats the watchdog.
    assign w_timeout   = (r_state == WAIT) && !(m_rvalid || m_wvalid) && (r_cnt == CNT_LAST);
    assign w_owner     = r_slot.owner[PTR_W-1:0];
    assign w_owner_hot = NUM_PORTS'(1) << w_owner;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     if (w_any_pending) w_state_next = w_illegal ? ERR : ISSUE;
            ISSUE:   if (m_rdy) w_state_next = WAIT;
            WAIT:    if (w_done_ok || w_timeout) w_state_next = ARB;
            ERR:     w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    always_comb begin
        req_rdy    = '0;
        rsp_rvalid = '0;
        rsp_wvalid = '0;
        rsp_error  = '0;
        rsp_rdata  = '0;
        if (rst_n && w_accept) begin
            req_rdy[w_grant] = 1'b1;
        end
        if (w_done_ok) begin
            if (m_rvalid) begin
                rsp_rvalid = w_owner_hot;
                rsp_rdata  = m_rdata;
            end
            if (m_wvalid) rsp_wvalid = w_owner_hot;
            if (m_error)  rsp_error  = w_owner_hot;
        end
        if (w_timeout || (r_state == ERR)) begin
            rsp_error = w_owner_hot;
        end
    end

    assign m_rd           = (r_state == ISSUE) && r_slot.rd;
    assign m_wr           = (r_state == ISSUE) ? r_slot.wr[WORD_LEN-1:0] : '0;
    assign m_addr         = r_slot.addr[ADDR_WIDTH-1:0];
    assign m_wdata        = r_slot.wdata[DATA_WIDTH-1:0];
    assign busy           = (r_state != ARB);
    assign timeout_sticky = r_timeout_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot           <= '0;
            r_ptr            <= PTR_W'(NUM_PORTS - 1);
            r_cnt            <= '0;
            r_timeout_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                // An rd+wr request is still consumed, but carries no command to the core.
                r_ptr        <= w_grant;
                r_slot.rd    <= w_grant_rd && !w_illegal;
                r_slot.wr    <= w_illegal ? '0 : SLOT_BE_MAX'(w_grant_wr);
                r_slot.addr  <= SLOT_ADDR_MAX'(req_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH]);
                r_slot.wdata <= SLOT_DATA_MAX'(req_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH]);
                r_slot.owner <= SLOT_OWNER_MAX'(w_grant);
            end
            if ((r_state == ISSUE) && m_rdy) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_sticky <= 1'b1;
            end
        end
    end

    assign w_unused = ^{r_slot.addr, r_slot.wdata, r_slot.wr, r_slot.owner};

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter with a latency-programmable core model
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int WL = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NP-1:0]      req_rd = '0;
    logic [NP*WL-1:0]   req_wr = '0;
    logic [NP*AW-1:0]   req_addr = '0;
    logic [NP*DW-1:0]   req_wdata = '0;
    logic [NP-1:0]      req_rdy, rsp_rvalid, rsp_wvalid, rsp_error;
    logic [DW-1:0]      rsp_rdata;
    logic               m_rd;
    logic [WL-1:0]      m_wr;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_rdy = 1'b1;
    logic               m_rvalid = 1'b0;
    logic               m_wvalid = 1'b0;
    logic [DW-1:0]      m_rdata = '0;
    logic               m_error = 1'b0;
    logic               busy, timeout_sticky;

    sdram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdy(req_rdy), .rsp_rvalid(rsp_rvalid), .rsp_wvalid(rsp_wvalid),
        .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdy(m_rdy), .m_rvalid(m_rvalid), .m_wvalid(m_wvalid),
        .m_rdata(m_rdata), .m_error(m_error),
        .busy(busy), .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd;
        logic [WL-1:0] wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [NP-1:0] rv;
        logic [NP-1:0] wv;
        logic [NP-1:0] er;
        logic [DW-1:0] rdata;
    } rsp_t;

    req_t    port_q[NP][$];
    req_t    cur[NP];
    bit      active[NP];
    bit      granted[NP];
    rsp_t    exp_q[$];
    int      exp_grant[$];
    int      wv_count[NP];
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      grant_cnt = 0;
    int      grant_cyc = 0;
    int      last_rsp_cyc = 0;
    int      grant_gap = 0;
    int      cmd_cycles = 0;
    int      exp_lat = 0;
    int      core_lat = 5;
    int      core_cnt = 0;
    bit      core_is_rd = 1'b0;
    bit      core_dead = 1'b0;
    bit      acc_pend = 1'b0;
    bit      acc_rd = 1'b0;
    logic [DW-1:0] core_rdata = 16'hBEEF;
    rsp_t    mon_act;
    rsp_t    mon_exp;
    int      mon_g;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic rd, input logic [WL-1:0] wr,
                                    input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_t r;
        r.rd    = rd;
        r.wr    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic rsp_t make_exp(input int p, input req_t r);
        rsp_t e;
        e = '0;
        if ((r.rd && (r.wr != '0)) || core_dead) e.er[p] = 1'b1;
        else if (r.rd) begin
            e.rv[p]  = 1'b1;
            e.rdata  = core_rdata;
        end else e.wv[p] = 1'b1;
        return e;
    endfunction

    function automatic bit idle();
        bit ok;
        ok = (exp_q.size() == 0) && (exp_grant.size() == 0) && !busy;
        for (int p = 0; p < NP; p++) begin
            if (active[p] || (port_q[p].size() != 0)) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic wait_grant(input int bound);
        int start;
        int n;
        start = grant_cnt;
        n = 0;
        while ((grant_cnt == start) && (n < bound)) begin
            @(posedge clk); #3;
            n++;
        end
        if (grant_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL wait_grant: no grant within %0d cycles", bound);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!idle() && (n < bound)) begin
            @(posedge clk); #3;
            n++;
        end
        if (!idle()) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: outstanding work after %0d cycles (exp_q=%0d)", bound, exp_q.size());
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester side: each port holds its request until the monitor has seen req_rdy.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (granted[p]) begin
                    active[p]  = 1'b0;
                    granted[p] = 1'b0;
                end
                if (!active[p] && (port_q[p].size() != 0)) begin
                    cur[p]    = port_q[p].pop_front();
                    active[p] = 1'b1;
                end
                if (!active[p]) cur[p] = '0;
                req_rd[p]              = cur[p].rd;
                req_wr[p*WL +: WL]     = cur[p].wr;
                req_addr[p*AW +: AW]   = cur[p].addr;
                req_wdata[p*DW +: DW]  = cur[p].wdata;
            end
        end
    end

    // Core model: completes core_lat cycles after acceptance unless core_dead.
    initial begin
        forever begin
            @(posedge clk); #1;
            m_rvalid = 1'b0;
            m_wvalid = 1'b0;
            if (!rst_n) begin
                core_cnt = 0;
                acc_pend = 1'b0;
            end else begin
                if (acc_pend) begin
                    core_cnt   = core_lat;
                    core_is_rd = acc_rd;
                    acc_pend   = 1'b0;
                end
                if (core_cnt > 0) begin
                    core_cnt--;
                    if ((core_cnt == 0) && !core_dead) begin
                        if (core_is_rd) m_rvalid = 1'b1;
                        else m_wvalid = 1'b1;
                    end
                end
            end
            m_rdata = core_rdata;
        end
    end

    // Monitor: grants are checked against the expected order, responses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (m_rd || (m_wr != '0)) begin
                cmd_cycles++;
                if (m_rdy) begin
                    acc_pend = 1'b1;
                    acc_rd   = m_rd;
                end
            end
            if (req_rdy != '0) begin
                if (exp_grant.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: req_rdy=0x%0h with no grant expected", req_rdy);
                end else begin
                    mon_g = exp_grant.pop_front();
                    check("grant_port", req_rdy, 128'(NP'(1) << mon_g));
                end
                for (int p = 0; p < NP; p++) begin
                    if (req_rdy[p]) begin
                        granted[p] = 1'b1;
                        exp_q.push_back(make_exp(p, cur[p]));
                    end
                end
                grant_cnt++;
                grant_gap = cyc - last_rsp_cyc;
                grant_cyc = cyc;
            end
            if ((rsp_rvalid | rsp_wvalid | rsp_error) != '0) begin
                last_rsp_cyc = cyc;
                mon_act = {rsp_rvalid, rsp_wvalid, rsp_error, rsp_rdata};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got 0x%0h with empty scoreboard", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rsp", mon_act, mon_exp);
                end
                if (exp_lat != 0) check("rsp_latency", cyc - grant_cyc, exp_lat);
                for (int p = 0; p < NP; p++) begin
                    if (rsp_wvalid[p]) wv_count[p]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        int stable;
        for (int p = 0; p < NP; p++) wv_count[p] = 0;

        repeat (2) @(posedge clk);
        #3;
        check("reset_outputs", {req_rdy, rsp_rvalid, rsp_wvalid, rsp_error, rsp_rdata,
                                m_rd, m_wr, m_addr, m_wdata, busy, timeout_sticky}, '0);
        rst_n = 1'b1;
        @(posedge clk); #3;

        // Single read on port 2, latency 5: response 6 cycles after the grant.
        core_lat = 5;
        exp_lat  = 6;
        exp_grant.push_back(2);
        port_q[2].push_back(mk_req(1'b1, 2'b00, 25'h000100, 16'h0000));
        wait_grant(20);
        check("issue_cmd", {m_rd, m_wr, m_addr}, {1'b1, 2'b00, 25'h000100});
        wait_idle(50);

        // Fairness: pointer sits at 2, so four continuous writers are served 3,0,1,2,3,0,1,2.
        core_lat = 2;
        exp_lat  = 0;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) begin
                port_q[p].push_back(mk_req(1'b0, 2'b11, AW'(32'h1000 + p * 4 + k), DW'(16'hA000 + p)));
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp_grant.push_back(3);
            exp_grant.push_back(0);
            exp_grant.push_back(1);
            exp_grant.push_back(2);
        end
        wait_idle(300);
        for (int p = 0; p < NP; p++) check("fair_wvalid_count", wv_count[p], 2);

        // Refresh stall: command must hold for 40 cycles without error.
        m_rdy = 1'b0;
        exp_grant.push_back(2);
        port_q[2].push_back(mk_req(1'b0, 2'b11, 25'h002000, 16'h1234));
        wait_grant(20);
        stable = 0;
        for (int i = 0; i < 40; i++) begin
            if (!m_rd && (m_wr == 2'b11) && (m_addr == 25'h002000) && (m_wdata == 16'h1234) &&
                (rsp_error == '0) && busy) stable++;
            @(posedge clk); #3;
        end
        check("stall_stable_cycles", stable, 40);
        m_rdy = 1'b1;
        wait_idle(50);

        // Illegal rd+wr on port 1: error one cycle after grant, no core command.
        snap    = cmd_cycles;
        exp_lat = 1;
        exp_grant.push_back(1);
        port_q[1].push_back(mk_req(1'b1, 2'b01, 25'h000300, 16'h0000));
        wait_idle(20);
        check("illegal_no_core_cmd", cmd_cycles, snap);
        check("sticky_before_timeout", timeout_sticky, 1'b0);

        // Timeout: dead core, error 65 cycles after grant (64 after acceptance); port 3 next.
        core_dead = 1'b1;
        exp_lat   = 65;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        port_q[0].push_back(mk_req(1'b1, 2'b00, 25'h000400, 16'h0000));
        wait_grant(20);
        port_q[3].push_back(mk_req(1'b0, 2'b10, 25'h000500, 16'h5555));
        wait_idle(250);
        check("timeout_sticky_set", timeout_sticky, 1'b1);
        check("grant_after_timeout_gap", grant_gap, 1);
        core_dead = 1'b0;

        // Async reset mid-WAIT with all ports pending.
        core_lat = 20;
        exp_lat  = 0;
        exp_grant.push_back(1);
        port_q[1].push_back(mk_req(1'b1, 2'b00, 25'h000600, 16'h0000));
        wait_grant(20);
        repeat (4) begin
            @(posedge clk); #3;
        end
        for (int p = 0; p < NP; p++) begin
            port_q[p].push_back(mk_req(1'b0, 2'b01, AW'(32'h700 + p), DW'(16'h7000 + p)));
        end
        @(posedge clk); #3;
        check("wait_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", {req_rdy, rsp_rvalid, rsp_wvalid, rsp_error, rsp_rdata,
                                      m_rd, m_wr, m_addr, m_wdata, busy, timeout_sticky}, '0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3;
        core_lat = 3;
        for (int p = 0; p < NP; p++) exp_grant.push_back(p);
        rst_n = 1'b1;
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
